shift_seq_ctrl: RTL and testbench

- Command-driven sequencer for a WIDTH-bit parallel-in/parallel-out register.
- Accepts one command at a time over a valid/ready handshake: parallel load, shift left, shift right or rotate left, for a programmable number of cycles.
- Signals completion with a one-cycle done pulse.
- Owns the datapath register, so one upstream master can load, serialise or rotate data through the register without touching clock-level control.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_seq_ctrl_if.sv | 25 ++
 rtl/shift_dp.sv | 18 +
 rtl/shift_seq_ctrl.sv | 58 +++++
 tb/tb_shift_seq_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op, state and datapath-mode encodings shared by the shift sequencer
package shift_seq_pkg;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_ROTL = 2'b11;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [2:0] DP_HOLD = 3'd0;
   localparam logic [2:0] DP_LOAD = 3'd1;
   localparam logic [2:0] DP_SHL  = 3'd2;
   localparam logic [2:0] DP_SHR  = 3'd3;
   localparam logic [2:0] DP_ROTL = 3'd4;
   function automatic logic [2:0] dp_mode(input logic [1:0] op);
      return op == OP_LOAD ? DP_LOAD :
             op == OP_SHL  ? DP_SHL  :
             op == OP_SHR  ? DP_SHR  : DP_ROTL;
   endfunction
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: command/status bundle for shift_seq_ctrl; abort/aborted exist only with SHIFT_SEQ_ABORT_EN
interface shift_seq_ctrl_if #(parameter int WIDTH = 4, parameter int CNT_W = 3);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_cnt;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
   logic             abort;
   logic             aborted;
   modport master (output cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in, abort,
                   input  cmd_ready, q, busy, done, aborted);
   modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in, abort,
                   output cmd_ready, q, busy, done, aborted);
`else
   modport master (output cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in,
                   input  cmd_ready, q, busy, done);
   modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_cnt, ser_in,
                   output cmd_ready, q, busy, done);
`endif
endinterface

// File: rtl/shift_dp.sv
// shift_dp: WIDTH-bit load/shift/rotate register steered purely by a mode select
module shift_dp #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q
);
   import shift_seq_pkg::*;
   // one register update per clock according to mode; anything unknown holds
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else q <= mode == DP_LOAD ? data :
                mode == DP_SHL  ? {q[WIDTH-2:0], ser_in} :
                mode == DP_SHR  ? {ser_in, q[WIDTH-1:1]} :
                mode == DP_ROTL ? {q[WIDTH-2:0], q[WIDTH-1]} : q;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer (IDLE/EXEC/DONE) driving shift_dp; abort support under SHIFT_SEQ_ABORT_EN
module shift_seq_ctrl #(parameter int WIDTH = 4, parameter int CNT_W = 3) (
   input logic             clk,
   input logic             rst,
   shift_seq_ctrl_if.slave bus
);
   import shift_seq_pkg::*;
   logic [1:0]       state;
   logic [1:0]       op;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       mode;
   logic             abort_now;
   logic             accept;
   logic             go;
   logic             fin;
`ifdef SHIFT_SEQ_ABORT_EN
   logic             ab;
   assign abort_now = bus.abort;
   // flag an abort-terminated command for exactly its DONE cycle
   always_ff @(posedge clk) ab <= !rst && state == S_EXEC && abort_now;
   assign bus.aborted = ab && !rst;
`else
   assign abort_now = 1'b0;
`endif
   assign bus.cmd_ready = state == S_IDLE && !rst;
   assign bus.busy      = state == S_EXEC && !rst;
   assign bus.done      = state == S_DONE && !rst;
   assign bus.q         = q;
   assign accept = bus.cmd_valid && bus.cmd_ready;
   assign go     = state == S_EXEC && !abort_now && (op == OP_LOAD || cnt != '0);
   assign fin    = op == OP_LOAD || cnt <= CNT_W'(1) || abort_now;
   assign mode   = go ? dp_mode(op) : DP_HOLD;
   // latch the command at the handshake, count shifts down, and sequence the states
   always_ff @(posedge clk)
      if (rst) begin
         state <= S_IDLE;
         op    <= '0;
         data  <= '0;
         cnt   <= '0;
      end else begin
         if (accept) begin
            op   <= bus.cmd_op;
            data <= bus.cmd_data;
            cnt  <= bus.cmd_cnt;
         end else if (go && op != OP_LOAD) cnt <= cnt - CNT_W'(1);
         state <= accept ? S_EXEC : state == S_EXEC ? (fin ? S_DONE : S_EXEC) : S_IDLE;
      end
   shift_dp #(.WIDTH(WIDTH)) u_dp (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .data  (data),
      .ser_in(bus.ser_in),
      .q     (q)
   );
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl; abort cases run when SHIFT_SEQ_ABORT_EN is defined
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         total = 0;
   int         bad = 0;
   logic [3:0] mq = '0;
   logic [3:0] done_q[$];
`ifdef SHIFT_SEQ_ABORT_EN
   logic       ab_q[$];
`endif
   shift_seq_ctrl_if #(.WIDTH(4), .CNT_W(3)) bus ();
   shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] step(input logic [1:0] op, input logic [3:0] v, input logic s);
      return op == OP_SHL ? {v[2:0], s} : op == OP_SHR ? {s, v[3:1]} : {v[2:0], v[3]};
   endfunction

   // scoreboard consumer: every done pulse must match the oldest expected result
   always @(negedge clk)
      if (bus.done) begin
         if (done_q.size() == 0) chk("spurious_done", bus.done, 0);
         else begin
            chk("done_q", bus.q, done_q.pop_front());
`ifdef SHIFT_SEQ_ABORT_EN
            chk("aborted", bus.aborted, ab_q.pop_front());
`endif
         end
      end

   task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input logic [2:0] n, input logic s);
      logic [3:0] steps[$];
      int g = 0;
      while (!bus.cmd_ready && g < 20) begin @(negedge clk); g++; end
      chk("ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_data = d;
      bus.cmd_cnt = n;
      bus.ser_in = s;
      if (op == OP_LOAD) mq = d;
      else for (int i = 0; i < int'(n); i++) begin
         mq = step(op, mq, s);
         steps.push_back(mq);
      end
      done_q.push_back(mq);
`ifdef SHIFT_SEQ_ABORT_EN
      ab_q.push_back(1'b0);
`endif
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op = ~op;
      bus.cmd_data = ~d;
      bus.cmd_cnt = ~n;
      chk("busy", bus.busy, 1);
      if (op == OP_LOAD || n == 0) @(negedge clk);
      else for (int k = 0; k < int'(n); k++) begin
         @(negedge clk);
         chk("step_q", bus.q, steps[k]);
         chk("step_busy", bus.busy, k < int'(n) - 1);
      end
      chk("done", bus.done, 1);
      chk("rdy_in_done", bus.cmd_ready, 0);
      @(negedge clk);
      chk("done_once", bus.done, 0);
      chk("rdy_back", bus.cmd_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_LOAD;
      bus.cmd_data = 4'hF;
      bus.cmd_cnt = '0;
      bus.ser_in = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      repeat (2) begin
         @(negedge clk);
         chk("rst_q", bus.q, 0);
         chk("rst_rdy", bus.cmd_ready, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_done", bus.done, 0);
      end
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      #1 chk("post_rst_rdy", bus.cmd_ready, 1);
      @(negedge clk);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_q", bus.q, 0);
      do_cmd(OP_LOAD, 4'b1010, 3'd0, 1'b0);
      do_cmd(OP_SHL, 4'b0000, 3'd2, 1'b1);
      do_cmd(OP_SHR, 4'b0000, 3'd3, 1'b0);
      do_cmd(OP_LOAD, 4'b1000, 3'd0, 1'b0);
      do_cmd(OP_ROTL, 4'b0000, 3'd0, 1'b0);
      do_cmd(OP_ROTL, 4'b0000, 3'd5, 1'b0);
      do_cmd(OP_ROTL, 4'b0000, 3'd4, 1'b0);
      do_cmd(OP_SHR, 4'b0000, 3'd7, 1'b1);
      repeat (8) do_cmd(2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      do_cmd(OP_LOAD, 4'b1000, 3'd0, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_SHL;
      bus.cmd_cnt = 3'd7;
      bus.ser_in = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("mid_busy", bus.busy, 1);
      repeat (2) @(negedge clk);
      chk("pre_rst_q", bus.q, 4'b0011);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_q", bus.q, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_rdy", bus.cmd_ready, 0);
      rst = 1'b0;
      mq = '0;
      @(negedge clk);
      chk("after_rst_rdy", bus.cmd_ready, 1);
      chk("after_rst_done", bus.done, 0);
`ifdef SHIFT_SEQ_ABORT_EN
      do_cmd(OP_LOAD, 4'b0110, 3'd0, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_SHL;
      bus.cmd_cnt = 3'd7;
      bus.ser_in = 1'b0;
      done_q.push_back(4'b1000);
      ab_q.push_back(1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_abort_q", bus.q, 4'b1000);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_done", bus.done, 1);
      chk("abort_q", bus.q, 4'b1000);
      @(negedge clk);
      chk("aborted_clear", bus.aborted, 0);
      chk("abort_done_once", bus.done, 0);
      chk("abort_rdy", bus.cmd_ready, 1);
`endif
      chk("sb_empty", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
